// File: rtl/sum_display_driver.sv
// Shows the 5-bit adder result (0-31) as two decimal digits on a
// common-anode, time-multiplexed two-digit seven-segment display.
// Define LEADING_ZERO_BLANK_EN to blank the tens digit whenever it is zero.
module sum_display_driver #(
   parameter int CLK_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] sum,
   input  logic       load,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

   localparam logic [6:0] SegBlank = 7'h7F;
   localparam logic [1:0] AnOff    = 2'b11;
   localparam logic [1:0] AnOnes   = 2'b10;
   localparam logic [1:0] AnTens   = 2'b01;

   typedef enum logic {
      ONES = 1'b0,
      TENS = 1'b1
   } digitSel_e;

   logic [4:0]      value_q, value_d;
   logic [1:0]      tens_q, tens_d;
   logic [3:0]      ones_q, ones_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   digitSel_e       state_q, state_d;
   logic [6:0]      seg_q, seg_d;
   logic [1:0]      an_q, an_d;
   logic [3:0]      shownDigit;

   // Active-low gfedcba patterns; anything outside 0-9 goes dark.
   function automatic logic [6:0] segPattern(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = 7'h40;
         4'd1:    pat = 7'h79;
         4'd2:    pat = 7'h24;
         4'd3:    pat = 7'h30;
         4'd4:    pat = 7'h19;
         4'd5:    pat = 7'h12;
         4'd6:    pat = 7'h02;
         4'd7:    pat = 7'h78;
         4'd8:    pat = 7'h00;
         4'd9:    pat = 7'h10;
         default: pat = SegBlank;
      endcase
      return pat;
   endfunction

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = sum;
      end
   end

   // Value never exceeds 31, so three compare stages give the tens digit
   // and a single constant subtract leaves the ones digit.
   always_comb begin
      tens_d = 2'd0;
      ones_d = value_q[3:0];
      if (value_q >= 5'd30) begin
         tens_d = 2'd3;
         ones_d = 4'(value_q - 5'd30);
      end else if (value_q >= 5'd20) begin
         tens_d = 2'd2;
         ones_d = 4'(value_q - 5'd20);
      end else if (value_q >= 5'd10) begin
         tens_d = 2'd1;
         ones_d = 4'(value_q - 5'd10);
      end
   end

   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      state_d = state_q;
      if (cnt_q == CntMax) begin
         cnt_d   = '0;
         state_d = (state_q == ONES) ? TENS : ONES;
      end
   end

   // Outputs follow the current state, so the toggle made at the wrap edge
   // appears on the display one edge later, giving exactly CLK_DIV lit cycles.
   always_comb begin
      shownDigit = {2'b00, tens_q};
      an_d       = AnTens;
      if (state_q == ONES) begin
         shownDigit = ones_q;
         an_d       = AnOnes;
      end
      seg_d = segPattern(shownDigit);
`ifdef LEADING_ZERO_BLANK_EN
      if (state_q == TENS && tens_q == 2'd0) begin
         seg_d = SegBlank;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         cnt_q   <= '0;
         state_q <= ONES;
         seg_q   <= SegBlank;
         an_q    <= AnOff;
      end else begin
         value_q <= value_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule
